// File: rtl/mem_stage.sv
// Memory stage: data-memory req/ack access, branch resolve, forwarding taps and MEM/WB register.
// Optional access watchdog enabled by defining MEM_STAGE_TIMEOUT_EN.
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        WB_EN_in,
    input  logic        MEM_R_EN_in,
    input  logic        MEM_W_EN_in,
    input  logic        MEM_TO_REG_in,
    input  logic        is_BRANCH_in,
    input  logic        zero_in,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [4:0]  regD_in,
    input  logic [31:0] PCNEXT_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        branch_taken,
    output logic [31:0] branch_target,
    output logic        fwd_RegW_en,
    output logic [4:0]  fwd_regD,
    output logic [31:0] fwd_data,
    output logic        wb_WB_EN,
    output logic        wb_MEM_TO_REG,
    output logic [4:0]  wb_regD,
    output logic [31:0] wb_alu_data,
    output logic [31:0] wb_mem_data,
    output logic        bus_error
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t state;
    logic   mem_op;
    logic   abandon;
    logic   complete_read;

    assign mem_op        = MEM_R_EN_in | MEM_W_EN_in;
    assign dmem_req      = ~reset & (mem_op | (state == WAIT));
    assign dmem_we       = MEM_W_EN_in;
    assign dmem_addr     = {alu_result[31:2], 2'b00};
    assign dmem_wdata    = store_data;
    assign stall         = dmem_req & ~dmem_ack & ~abandon;
    // A simultaneous read/write request is treated as a write, so no load data.
    assign complete_read = dmem_req & dmem_ack & MEM_R_EN_in & ~MEM_W_EN_in;

    assign branch_taken  = ~reset & is_BRANCH_in & zero_in;
    assign branch_target = PCNEXT_in;

    assign fwd_RegW_en   = WB_EN_in;
    assign fwd_regD      = regD_in;
    assign fwd_data      = alu_result;

`ifdef MEM_STAGE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wait_count;

    // Ack in the final allowed cycle still completes normally.
    assign abandon   = dmem_req & ~dmem_ack & (wait_count == CW'(TIMEOUT_CYCLES - 1));
    assign bus_error = abandon;

    always_ff @(posedge clk) begin
        if (reset || !dmem_req || dmem_ack || abandon) begin
            wait_count <= '0;
        end else begin
            wait_count <= wait_count + CW'(1);
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign abandon            = 1'b0;
    assign bus_error          = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    state <= stall ? WAIT : IDLE;
                WAIT:    state <= stall ? WAIT : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // While stalled only the valid bit drops; the payload keeps its old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_WB_EN      <= 1'b0;
            wb_MEM_TO_REG <= 1'b0;
            wb_regD       <= '0;
            wb_alu_data   <= '0;
            wb_mem_data   <= '0;
        end else if (stall) begin
            wb_WB_EN      <= 1'b0;
        end else begin
            wb_WB_EN      <= WB_EN_in & ~abandon;
            wb_MEM_TO_REG <= MEM_TO_REG_in;
            wb_regD       <= regD_in;
            wb_alu_data   <= alu_result;
            wb_mem_data   <= complete_read ? dmem_rdata : 32'd0;
        end
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the five-stage pipeline: consumes the EX/MEM register fields produced by the execute stage, runs loads and stores on a variable-latency data-memory bus with a req/ack handshake, and resolves branches. It drives the memory-stage forwarding taps, back-pressures the front of the pipeline while a memory access is outstanding, and holds the MEM/WB pipeline register.

## Interface
- TIMEOUT_CYCLES, 255, count of unacknowledged request cycles before the access is abandoned (≥1; used only with MEM_STAGE_TIMEOUT_EN)
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, MEM_TO_REG_in, is_BRANCH_in, zero_in  in  1 each  EX/MEM control fields
- alu_result  in  32  ALU result / memory byte address
- store_data  in  32  forwarded rt data for stores
- regD_in  in  5  destination register
- PCNEXT_in  in  32  branch target
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word-aligned byte address
- dmem_wdata  out  32  store data
- dmem_ack  in  1  access complete
- dmem_rdata  in  32  load data, valid with dmem_ack
- stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM (drives EN_REG low)
- branch_taken  out  1  redirect fetch to branch_target
- branch_target  out  32  = PCNEXT_in
- fwd_RegW_en, fwd_regD, fwd_data  out  1/5/32  memory-stage forwarding tap
- wb_WB_EN, wb_MEM_TO_REG  out  1 each  MEM/WB control
- wb_regD  out  5  MEM/WB destination
- wb_alu_data, wb_mem_data  out  32 each  MEM/WB data
- bus_error  out  1  one-cycle pulse on abandoned access

## Operation
- mem_op = MEM_R_EN_in | MEM_W_EN_in; MEM_W_EN_in has priority when both are set (the access is a write, wb_mem_data = 0).
- FSM states: IDLE and WAIT.
  - IDLE: when mem_op is set, dmem_req = 1 combinationally. dmem_addr = {alu_result[31:2], 2'b00}, dmem_we = MEM_W_EN_in, dmem_wdata = store_data.
    - If dmem_ack is set in the same cycle, the access completes and the FSM stays in IDLE.
    - Otherwise the FSM goes to WAIT.
  - WAIT: dmem_req = 1 with identical addr/we/wdata; these are stable because EX/MEM is frozen.
    - On dmem_ack, the access completes and the FSM goes to IDLE.
- stall = dmem_req & ~dmem_ack & ~abandon. This is combinational, so the completing cycle does not stall.
- dmem_ack is ignored when dmem_req = 0.
- MEM/WB update, every edge when not in reset:
  - stall = 0: wb_WB_EN ← WB_EN_in & ~abandon. wb_regD, wb_MEM_TO_REG, and wb_alu_data ← alu_result are loaded.
  - stall = 0, completing read: wb_mem_data ← dmem_rdata. Otherwise wb_mem_data ← 0.
  - stall = 1: a bubble is loaded (wb_WB_EN ← 0, other fields unchanged).
- branch_taken = is_BRANCH_in & zero_in (combinational). Branch instructions never raise stall.
- fwd_RegW_en = WB_EN_in, fwd_regD = regD_in, fwd_data = alu_result.
  - These taps are combinational.
  - A load's result is not forwarded from this stage; load-use hazards are handled in decode.
- Reset:
  - State → IDLE, timeout counter → 0.
  - All wb_* outputs → 0.
  - dmem_req, stall, bus_error and branch_taken are forced to 0 while reset is high.
  - The memory accepts an abandoned request.

## Timing
- Zero-wait access: req and ack fall in the same cycle N. stall stays 0 and MEM/WB holds the result after edge N.
- k-cycle ack latency (ack in cycle N+k):
  - req is high in cycles N…N+k.
  - stall is high in cycles N…N+k-1.
  - MEM/WB receives k bubbles, then the result after edge N+k.
- Reset asserted in WAIT: req and stall drop in the reset cycle. No write-back entry is produced for the aborted op.
- Pipeline throughput is one instruction per cycle when every access is acknowledged in the same cycle.

## Configuration
- MEM_STAGE_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) counts cycles with dmem_req & ~dmem_ack. It clears on completion and on reset.
  - abandon = 1 on the TIMEOUT_CYCLES-th unacknowledged cycle. In that cycle:
    - bus_error = 1 and stall = 0.
    - MEM/WB captures the op with wb_WB_EN = 0.
    - The FSM goes to IDLE and the counter clears.
  - An ack arriving in the abandon cycle wins: normal completion, no error.
- MEM_STAGE_TIMEOUT_EN undefined: abandon = 0, bus_error is tied to 0, and the stage waits for ack indefinitely.

## Test plan
- Zero-wait load:
  - Stimulus: alu_result=0x13, MEM_R_EN_in=1, WB_EN_in=1, MEM_TO_REG_in=1, regD_in=5; ack in the same cycle with rdata=0xDEADBEEF.
  - Response: dmem_addr=0x10 and stall is never 1. The next cycle shows wb_mem_data=0xDEADBEEF, wb_regD=5, wb_WB_EN=1.
- Store with 3-cycle ack latency:
  - Stimulus: alu_result=0x20, store_data=0xCAFEF00D.
  - Response: req=1 and we=1 for 4 cycles with stable addr/wdata; stall=1 for 3 cycles; MEM/WB shows 3 bubbles, then an entry with wb_WB_EN=0.
- Branch:
  - is_BRANCH_in=1, zero_in=1, PCNEXT_in=0x40 → branch_taken=1, branch_target=0x40.
  - zero_in=0 → branch_taken=0.
  - stall stays 0 in both cases.
- Forwarding:
  - Stimulus: R-type with alu_result=0x1234, regD_in=7, WB_EN_in=1.
  - Response: same cycle fwd_RegW_en=1, fwd_regD=7, fwd_data=0x1234; next cycle wb_alu_data=0x1234.
- Timeout (MEM_STAGE_TIMEOUT_EN, TIMEOUT_CYCLES=4):
  - Stimulus: load with no ack.
  - Response: stall=1 for 3 cycles; in the 4th cycle bus_error=1 and stall=0; then req=0 and wb_WB_EN=0.
- Reset mid-WAIT:
  - Stimulus: reset for 1 cycle during a pending load.
  - Response: req=0 and stall=0 in the reset cycle; after the edge all wb_* outputs are 0 and the FSM is IDLE; a later ack is ignored.
